mm_tile_scheduler: RTL and testbench

- Sequences a multi-tile matrix multiply through one MM_buffer instance.
- Accepts one job command, then per tile: issues weight-fetch and feature-fetch descriptors to the DMA read engines, waits for the MM_buffer output last beat, then advances.
- Drives the MM_buffer configuration inputs FL and num_blobk_W; holds them stable for the whole job.
- Sits between the layer-control registers and the MM_buffer/DMA pair.

---
 rtl/mm_pkg.sv | 23 ++
 rtl/mm_req_issuer.sv | 36 +++
 rtl/mm_tile_scheduler.sv | 176 +++++++++++++++++
 tb/tb_mm_tile_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and defaults for the matrix-multiply tile scheduler.
// Holds the FSM state encoding, default widths and the weight beat-length helper.
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RUN = 2'd2,
    FINISH   = 2'd3
  } state_t;

  localparam int ARRAY_M_DEF        = 3;
  localparam int F_LENGTH_W_DEF     = 10;
  localparam int W_BLK_NUM_W_DEF    = 5;
  localparam int ADDR_W_DEF         = 32;
  localparam int TILE_CNT_W_DEF     = 8;

  // Weight beats per tile: one array_m-beat burst per block column.
  function automatic logic [31:0] beat_len(input logic [31:0] num_blk, input logic [31:0] m);
    return num_blk * m;
  endfunction

endpackage

// File: rtl/mm_req_issuer.sv
// Single valid/ready descriptor holder for one DMA read engine.
// load arms a new descriptor; addr/len hold while valid; accepted marks the handshake.
module mm_req_issuer #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [LEN_W-1:0]  req_len,
  output logic              accepted
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_len   <= '0;
      accepted  <= 1'b0;
    end else if (load) begin
      req_valid <= 1'b1;
      req_addr  <= load_addr;
      req_len   <= load_len;
      accepted  <= 1'b0;
    end else if (req_valid && req_ready) begin
      req_valid <= 1'b0;
      accepted  <= 1'b1;
    end
  end

endmodule

// File: rtl/mm_tile_scheduler.sv
// Sequences a multi-tile matrix multiply: per tile issues weight/feature DMA
// descriptors, waits for MM_buffer last beat. Optional MM_SCHED_PERF_EN adds perf counters.
//
// state    | meaning
// IDLE     | cmd_ready high, waiting for a job command
// ISSUE    | weight and feature descriptors outstanding until both handshake
// WAIT_RUN | waiting for MM_buffer last beat of the current tile
// FINISH   | one-cycle done pulse, then back to IDLE
module mm_tile_scheduler
  import mm_pkg::*;
#(
  parameter int array_m                 = ARRAY_M_DEF,
  parameter int F_length_width          = F_LENGTH_W_DEF,
  parameter int W_width_block_num_width = W_BLK_NUM_W_DEF,
  parameter int addr_width              = ADDR_W_DEF,
  parameter int tile_cnt_width          = TILE_CNT_W_DEF
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              cmd_valid,
  output logic                                              cmd_ready,
  input  logic [tile_cnt_width-1:0]                         cmd_num_tiles,
  input  logic [F_length_width-1:0]                         cmd_FL,
  input  logic [W_width_block_num_width-1:0]                cmd_num_blk_W,
  input  logic [addr_width-1:0]                             cmd_w_base,
  input  logic [addr_width-1:0]                             cmd_f_base,
  input  logic [addr_width-1:0]                             cmd_w_stride,
  input  logic [addr_width-1:0]                             cmd_f_stride,
  output logic [F_length_width-1:0]                         FL,
  output logic [W_width_block_num_width-1:0]                num_blobk_W,
  output logic                                              w_req_valid,
  input  logic                                              w_req_ready,
  output logic [addr_width-1:0]                             w_req_addr,
  output logic [W_width_block_num_width+$clog2(array_m):0]  w_req_len,
  output logic                                              f_req_valid,
  input  logic                                              f_req_ready,
  output logic [addr_width-1:0]                             f_req_addr,
  output logic [F_length_width-1:0]                         f_req_len,
  input  logic                                              mm_out_last,
`ifdef MM_SCHED_PERF_EN
  output logic [31:0]                                       perf_busy_cycles,
  output logic [31:0]                                       perf_stall_cycles,
`endif
  output logic                                              busy,
  output logic                                              done,
  output logic                                              err
);

  localparam int WLEN_W = W_width_block_num_width + $clog2(array_m) + 1;

  state_t state_q, state_d;

  logic [tile_cnt_width-1:0]          num_tiles_q, tile_idx_q;
  logic [addr_width-1:0]              w_addr_q, f_addr_q, w_stride_q, f_stride_q;
  logic                               w_accepted, f_accepted;
  logic                               accept, zero_size, advance, last_tile, load;
  logic                               w_done, f_done;
  logic [addr_width-1:0]              w_load_addr, f_load_addr;
  logic [W_width_block_num_width-1:0] nblk_src;
  logic [WLEN_W-1:0]                  w_load_len;
  logic [F_length_width-1:0]          f_load_len;

  assign accept    = cmd_valid && cmd_ready;
  assign zero_size = (cmd_num_tiles == '0) || (cmd_FL == '0) || (cmd_num_blk_W == '0);
  assign last_tile = (tile_idx_q == num_tiles_q - tile_cnt_width'(1));
  assign advance   = (state_q == WAIT_RUN) && mm_out_last;
  assign w_done    = w_accepted || (w_req_valid && w_req_ready);
  assign f_done    = f_accepted || (f_req_valid && f_req_ready);

  // Arm both descriptors on the same edge that enters ISSUE so valid is up in its first cycle.
  assign load        = (accept && !zero_size) || (advance && !last_tile);
  assign w_load_addr = accept ? cmd_w_base : w_addr_q + w_stride_q;
  assign f_load_addr = accept ? cmd_f_base : f_addr_q + f_stride_q;
  assign nblk_src    = accept ? cmd_num_blk_W : num_blobk_W;
  assign w_load_len  = WLEN_W'(beat_len(32'(nblk_src), 32'(array_m)));
  assign f_load_len  = accept ? cmd_FL : FL;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept) state_d = zero_size ? FINISH : ISSUE;
      ISSUE:    if (w_done && f_done) state_d = WAIT_RUN;
      WAIT_RUN: if (mm_out_last) state_d = last_tile ? FINISH : ISSUE;
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = (state_q == FINISH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_tiles_q <= '0;
      tile_idx_q  <= '0;
      FL          <= '0;
      num_blobk_W <= '0;
      w_addr_q    <= '0;
      f_addr_q    <= '0;
      w_stride_q  <= '0;
      f_stride_q  <= '0;
      err         <= 1'b0;
    end else if (accept) begin
      num_tiles_q <= cmd_num_tiles;
      tile_idx_q  <= '0;
      FL          <= cmd_FL;
      num_blobk_W <= cmd_num_blk_W;
      w_addr_q    <= cmd_w_base;
      f_addr_q    <= cmd_f_base;
      w_stride_q  <= cmd_w_stride;
      f_stride_q  <= cmd_f_stride;
      err         <= (cmd_FL == '0) || (cmd_num_blk_W == '0) || mm_out_last;
    end else begin
      if (advance) begin
        tile_idx_q <= tile_idx_q + tile_cnt_width'(1);
        w_addr_q   <= w_addr_q + w_stride_q;
        f_addr_q   <= f_addr_q + f_stride_q;
      end
      if (mm_out_last && (state_q != WAIT_RUN)) err <= 1'b1;
    end
  end

  mm_req_issuer #(.ADDR_W(addr_width), .LEN_W(WLEN_W)) u_w_issuer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_addr (w_load_addr),
    .load_len  (w_load_len),
    .req_valid (w_req_valid),
    .req_ready (w_req_ready),
    .req_addr  (w_req_addr),
    .req_len   (w_req_len),
    .accepted  (w_accepted)
  );

  mm_req_issuer #(.ADDR_W(addr_width), .LEN_W(F_length_width)) u_f_issuer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_addr (f_load_addr),
    .load_len  (f_load_len),
    .req_valid (f_req_valid),
    .req_ready (f_req_ready),
    .req_addr  (f_req_addr),
    .req_len   (f_req_len),
    .accepted  (f_accepted)
  );

`ifdef MM_SCHED_PERF_EN
  logic stall;
  assign stall = (state_q == ISSUE) &&
                 ((w_req_valid && !w_req_ready) || (f_req_valid && !f_req_ready));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else if (accept) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy && (perf_busy_cycles != '1))   perf_busy_cycles  <= perf_busy_cycles + 32'd1;
      if (stall && (perf_stall_cycles != '1)) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mm_tile_scheduler.sv
// Directed bench for mm_tile_scheduler: table of jobs with hand-computed descriptors,
// plus sequences for stall, zero-size, spurious last beat and mid-job reset.
module tb_mm_tile_scheduler;

  typedef struct {
    logic [7:0]  tiles;
    logic [9:0]  fl;
    logic [4:0]  nblk;
    logic [31:0] wb, ws, fb, fs;
  } job_t;

  typedef struct {
    logic [31:0] w_addr;
    logic [7:0]  w_len;
    logic [31:0] f_addr;
    logic [9:0]  f_len;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_num_tiles;
  logic [9:0]  cmd_FL;
  logic [4:0]  cmd_num_blk_W;
  logic [31:0] cmd_w_base, cmd_f_base, cmd_w_stride, cmd_f_stride;
  logic [9:0]  FL;
  logic [4:0]  num_blobk_W;
  logic        w_req_valid, w_req_ready, f_req_valid, f_req_ready;
  logic [31:0] w_req_addr, f_req_addr;
  logic [7:0]  w_req_len;
  logic [9:0]  f_req_len;
  logic        mm_out_last, busy, done, err;
`ifdef MM_SCHED_PERF_EN
  logic [31:0] perf_busy_cycles, perf_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_idx = 0;
  job_t jobs[3];
  exp_t exp_d[6];

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt++;

  mm_tile_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_num_tiles (cmd_num_tiles),
    .cmd_FL        (cmd_FL),
    .cmd_num_blk_W (cmd_num_blk_W),
    .cmd_w_base    (cmd_w_base),
    .cmd_f_base    (cmd_f_base),
    .cmd_w_stride  (cmd_w_stride),
    .cmd_f_stride  (cmd_f_stride),
    .FL            (FL),
    .num_blobk_W   (num_blobk_W),
    .w_req_valid   (w_req_valid),
    .w_req_ready   (w_req_ready),
    .w_req_addr    (w_req_addr),
    .w_req_len     (w_req_len),
    .f_req_valid   (f_req_valid),
    .f_req_ready   (f_req_ready),
    .f_req_addr    (f_req_addr),
    .f_req_len     (f_req_len),
    .mm_out_last   (mm_out_last),
`ifdef MM_SCHED_PERF_EN
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_stall_cycles (perf_stall_cycles),
`endif
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input job_t j);
    cmd_num_tiles = j.tiles;
    cmd_FL        = j.fl;
    cmd_num_blk_W = j.nblk;
    cmd_w_base    = j.wb;
    cmd_w_stride  = j.ws;
    cmd_f_base    = j.fb;
    cmd_f_stride  = j.fs;
    cmd_valid     = 1'b1;
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Readies held high: each tile is one ISSUE cycle then one WAIT_RUN cycle.
  task automatic run_job(input job_t j);
    int d0;
    d0 = done_cnt;
    start_cmd(j);
    chk("err_after_accept", {31'd0, err}, 32'd0);
    for (int t = 0; t < int'(j.tiles); t++) begin
      chk("w_valid", {31'd0, w_req_valid}, 32'd1);
      chk("f_valid", {31'd0, f_req_valid}, 32'd1);
      chk("w_addr", w_req_addr, exp_d[exp_idx].w_addr);
      chk("w_len", {24'd0, w_req_len}, {24'd0, exp_d[exp_idx].w_len});
      chk("f_addr", f_req_addr, exp_d[exp_idx].f_addr);
      chk("f_len", {22'd0, f_req_len}, {22'd0, exp_d[exp_idx].f_len});
      exp_idx++;
      tick();
      chk("w_valid_drop", {31'd0, w_req_valid}, 32'd0);
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("done_early", {31'd0, done}, 32'd0);
      mm_out_last = 1'b1;
      tick();
      mm_out_last = 1'b0;
    end
    chk("done", {31'd0, done}, 32'd1);
    chk("busy_at_done", {31'd0, busy}, 32'd1);
    tick();
    chk("done_once", done_cnt - d0, 32'd1);
    chk("cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int d0;
    job_t j;

    jobs[0] = '{tiles: 8'd3, fl: 10'd8,    nblk: 5'd2,  wb: 32'h1000,     ws: 32'h40, fb: 32'h8000, fs: 32'h100};
    jobs[1] = '{tiles: 8'd2, fl: 10'd1,    nblk: 5'd31, wb: 32'hFFFF_FFC0, ws: 32'h40, fb: 32'h10,   fs: 32'hFFFF_FFF0};
    jobs[2] = '{tiles: 8'd1, fl: 10'd1023, nblk: 5'd1,  wb: 32'h0,        ws: 32'h4,  fb: 32'h20,   fs: 32'h0};
    exp_d[0] = '{w_addr: 32'h1000,      w_len: 8'd6,  f_addr: 32'h8000, f_len: 10'd8};
    exp_d[1] = '{w_addr: 32'h1040,      w_len: 8'd6,  f_addr: 32'h8100, f_len: 10'd8};
    exp_d[2] = '{w_addr: 32'h1080,      w_len: 8'd6,  f_addr: 32'h8200, f_len: 10'd8};
    exp_d[3] = '{w_addr: 32'hFFFF_FFC0, w_len: 8'd93, f_addr: 32'h10,   f_len: 10'd1};
    exp_d[4] = '{w_addr: 32'h0,         w_len: 8'd93, f_addr: 32'h0,    f_len: 10'd1};
    exp_d[5] = '{w_addr: 32'h0,         w_len: 8'd3,  f_addr: 32'h20,   f_len: 10'd1023};

    rst_n = 1'b0; cmd_valid = 1'b0; mm_out_last = 1'b0;
    w_req_ready = 1'b1; f_req_ready = 1'b1;
    cmd_num_tiles = '0; cmd_FL = '0; cmd_num_blk_W = '0;
    cmd_w_base = '0; cmd_f_base = '0; cmd_w_stride = '0; cmd_f_stride = '0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_FL", {22'd0, FL}, 32'd0);
    chk("rst_nblk", {27'd0, num_blobk_W}, 32'd0);
    chk("rst_w_valid", {31'd0, w_req_valid}, 32'd0);
    chk("rst_f_valid", {31'd0, f_req_valid}, 32'd0);
    tick();

    for (int i = 0; i < 2; i++) run_job(jobs[i]);
    chk("FL_hold", {22'd0, FL}, 32'd1);
    chk("nblk_hold", {27'd0, num_blobk_W}, 32'd31);

    // Zero tiles: straight to FINISH, no error.
    j = '{tiles: 8'd0, fl: 10'd5, nblk: 5'd2, wb: 32'h0, ws: 32'h0, fb: 32'h0, fs: 32'h0};
    start_cmd(j);
    chk("zt_done", {31'd0, done}, 32'd1);
    chk("zt_busy", {31'd0, busy}, 32'd1);
    chk("zt_err", {31'd0, err}, 32'd0);
    chk("zt_w_valid", {31'd0, w_req_valid}, 32'd0);
    chk("zt_FL", {22'd0, FL}, 32'd5);
    chk("zt_nblk", {27'd0, num_blobk_W}, 32'd2);
    tick();
    chk("zt_done_drop", {31'd0, done}, 32'd0);
    chk("zt_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // FL=0: error job, then a valid job clears err.
    j = '{tiles: 8'd2, fl: 10'd0, nblk: 5'd3, wb: 32'h0, ws: 32'h0, fb: 32'h0, fs: 32'h0};
    start_cmd(j);
    chk("fl0_done", {31'd0, done}, 32'd1);
    chk("fl0_err", {31'd0, err}, 32'd1);
    chk("fl0_f_valid", {31'd0, f_req_valid}, 32'd0);
    tick();
    chk("fl0_err_sticky", {31'd0, err}, 32'd1);
    run_job(jobs[2]);

    // f_req_ready low for 5 ISSUE cycles.
    j = '{tiles: 8'd1, fl: 10'd4, nblk: 5'd1, wb: 32'h200, ws: 32'h0, fb: 32'h300, fs: 32'h0};
    f_req_ready = 1'b0;
    start_cmd(j);
    for (int i = 0; i < 5; i++) begin
      chk("stall_f_valid", {31'd0, f_req_valid}, 32'd1);
      chk("stall_f_addr", f_req_addr, 32'h300);
      chk("stall_f_len", {22'd0, f_req_len}, 32'd4);
      chk("stall_w_valid", {31'd0, w_req_valid}, (i == 0) ? 32'd1 : 32'd0);
      tick();
    end
    f_req_ready = 1'b1;
    chk("stall_f_valid_end", {31'd0, f_req_valid}, 32'd1);
    tick();
    chk("stall_f_drop", {31'd0, f_req_valid}, 32'd0);
`ifdef MM_SCHED_PERF_EN
    chk("perf_stall", perf_stall_cycles, 32'd5);
`endif
    mm_out_last = 1'b1;
    tick();
    mm_out_last = 1'b0;
    chk("stall_done", {31'd0, done}, 32'd1);
    tick();
`ifdef MM_SCHED_PERF_EN
    chk("perf_busy", perf_busy_cycles, 32'd8);
    chk("perf_stall_hold", perf_stall_cycles, 32'd5);
`endif

    // Spurious last beat in ISSUE.
    j = '{tiles: 8'd2, fl: 10'd2, nblk: 5'd1, wb: 32'h100, ws: 32'h10, fb: 32'h200, fs: 32'h20};
    w_req_ready = 1'b0; f_req_ready = 1'b0;
    d0 = done_cnt;
    start_cmd(j);
    chk("sp_err_clear", {31'd0, err}, 32'd0);
    mm_out_last = 1'b1;
    tick();
    mm_out_last = 1'b0;
    chk("sp_err", {31'd0, err}, 32'd1);
    chk("sp_w_valid", {31'd0, w_req_valid}, 32'd1);
    chk("sp_w_addr", w_req_addr, 32'h100);
    w_req_ready = 1'b1; f_req_ready = 1'b1;
    tick();
    mm_out_last = 1'b1;
    tick();
    mm_out_last = 1'b0;
    chk("sp_t1_w_valid", {31'd0, w_req_valid}, 32'd1);
    chk("sp_t1_w_addr", w_req_addr, 32'h110);
    chk("sp_t1_f_addr", f_req_addr, 32'h220);
    tick();
    mm_out_last = 1'b1;
    tick();
    mm_out_last = 1'b0;
    chk("sp_done", {31'd0, done}, 32'd1);
    chk("sp_err_hold", {31'd0, err}, 32'd1);
    tick();
    chk("sp_done_once", done_cnt - d0, 32'd1);

    // Reset in WAIT_RUN of tile 1.
    j = '{tiles: 8'd2, fl: 10'd3, nblk: 5'd1, wb: 32'h40, ws: 32'h40, fb: 32'h0, fs: 32'h10};
    d0 = done_cnt;
    start_cmd(j);
    tick();
    mm_out_last = 1'b1;
    tick();
    mm_out_last = 1'b0;
    chk("rm_t1_w_addr", w_req_addr, 32'h80);
    tick();
    chk("rm_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rm_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rm_busy_low", {31'd0, busy}, 32'd0);
    chk("rm_done", {31'd0, done}, 32'd0);
    chk("rm_FL", {22'd0, FL}, 32'd0);
    chk("rm_w_valid", {31'd0, w_req_valid}, 32'd0);
    tick();
    chk("rm_no_done", done_cnt - d0, 32'd0);
    exp_idx = 0;
    run_job(jobs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
